// File: rtl/mac_pipe_stage.sv
// Two-stage valid/ready pipeline computing (a + b) * c on unsigned operands.
// Define MAC_PIPE_STATS_EN to add the o_beat_cnt / o_stall_cnt statistics outputs.
module mac_pipe_stage #(
    parameter  int WIDTH = 8,
    localparam int RES_W = 2 * WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [RES_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
`ifdef MAC_PIPE_STATS_EN
    output logic [31:0]      o_beat_cnt,
    output logic [31:0]      o_stall_cnt,
`endif
    output logic             o_busy
);

    logic             v1;
    logic             v2;
    logic [WIDTH:0]   ab;
    logic [WIDTH-1:0] c1;
    logic [RES_W-1:0] res;
    logic             adv1;
    logic             adv2;

    // A stage may load whenever it is empty or its contents leave this cycle.
    always_comb begin
        adv2 = !v2 || i_ready;
        adv1 = !v1 || adv2;
    end

    assign o_ready = adv1;
    assign o_valid = v2;
    assign o_data  = res;
    assign o_busy  = v1 || v2;

    // Stage 1 keeps a+b at full width so the product never loses a carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            ab <= '0;
            c1 <= '0;
        end else if (adv1) begin
            v1 <= i_valid;
            if (i_valid) begin
                ab <= {1'b0, i_a} + {1'b0, i_b};
                c1 <= i_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            res <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                res <= RES_W'(ab) * RES_W'(c1);
            end
        end
    end

`ifdef MAC_PIPE_STATS_EN
    // Free-running counters; they wrap naturally modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_beat_cnt  <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (v2 && i_ready) begin
                o_beat_cnt <= o_beat_cnt + 32'd1;
            end
            if (v2 && !i_ready) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_pipe_stage.sv
// Scoreboard bench for mac_pipe_stage: directed corner cases plus a randomized stream.
module tb_mac_pipe_stage;

    localparam int WIDTH = 8;
    localparam int RES_W = 2 * WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] c = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [RES_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
`ifdef MAC_PIPE_STATS_EN
    logic [31:0]      beat_cnt;
    logic [31:0]      stall_cnt;
    logic [31:0]      stall_snap;
`endif

    int     checks = 0;
    int     errors = 0;
    int     accepted = 0;
    longint exp_q[$];
    logic   held = 1'b0;
    logic [RES_W-1:0] held_data = '0;

    mac_pipe_stage #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_a         (a),
        .i_b         (b),
        .i_c         (c),
        .i_valid     (in_valid),
        .o_ready     (in_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
`ifdef MAC_PIPE_STATS_EN
        .o_beat_cnt  (beat_cnt),
        .o_stall_cnt (stall_cnt),
`endif
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input int av, input int bv, input int cv, input logic rdy);
        in_valid  = v;
        a         = WIDTH'(av);
        b         = WIDTH'(bv);
        c         = WIDTH'(cv);
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: decides at the falling edge what the coming rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("hold_valid", longint'(out_valid), 1);
                checkOutput("hold_data", longint'(out_data), longint'(held_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", longint'(out_data), -1);
                end else begin
                    checkOutput("result", longint'(out_data), exp_q.pop_front());
                end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back((longint'(a) + longint'(b)) * longint'(c));
                accepted++;
            end
        end
    end

    initial begin
        int cyc;

        // Reset state; o_ready is high even while reset is held.
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        tick();
        tick();
        checkOutput("ready_in_reset", longint'(in_ready), 1);
        rst = 1'b0;
        checkOutput("reset_valid", longint'(out_valid), 0);
        checkOutput("reset_data", longint'(out_data), 0);
        checkOutput("reset_busy", longint'(busy), 0);
`ifdef MAC_PIPE_STATS_EN
        checkOutput("reset_beat_cnt", longint'(beat_cnt), 0);
        checkOutput("reset_stall_cnt", longint'(stall_cnt), 0);
`endif

        // Single beat: two-cycle latency, busy for two cycles.
        applyStimulus(1'b1, 200, 100, 3, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("lat_valid_n1", longint'(out_valid), 0);
        checkOutput("lat_busy_n1", longint'(busy), 1);
        tick();
        checkOutput("lat_valid_n2", longint'(out_valid), 1);
        checkOutput("lat_data_n2", longint'(out_data), 900);
        checkOutput("lat_busy_n2", longint'(busy), 1);
        tick();
        checkOutput("lat_valid_n3", longint'(out_valid), 0);
        checkOutput("lat_busy_n3", longint'(busy), 0);

        // Back-to-back beats including the maximum product.
        applyStimulus(1'b1, 255, 255, 255, 1'b1);
        tick();
        checkOutput("b2b_ready", longint'(in_ready), 1);
        applyStimulus(1'b1, 1, 2, 3, 1'b1);
        tick();
        checkOutput("b2b_ready2", longint'(in_ready), 1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("b2b_valid1", longint'(out_valid), 1);
        checkOutput("b2b_data1", longint'(out_data), 130050);
        tick();
        checkOutput("b2b_valid2", longint'(out_valid), 1);
        checkOutput("b2b_data2", longint'(out_data), 9);
        tick();
        checkOutput("b2b_empty", longint'(out_valid), 0);

        // Full pipeline held for five cycles, then drained.
        applyStimulus(1'b1, 10, 20, 30, 1'b0);
        tick();
        applyStimulus(1'b1, 7, 8, 9, 1'b0);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("full_ready", longint'(in_ready), 0);
        checkOutput("full_data", longint'(out_data), 900);
`ifdef MAC_PIPE_STATS_EN
        stall_snap = stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_ready", longint'(in_ready), 0);
            checkOutput("stall_data", longint'(out_data), 900);
        end
`ifdef MAC_PIPE_STATS_EN
        checkOutput("stall_cnt_delta", longint'(stall_cnt - stall_snap), 5);
`endif
        out_ready = 1'b1;
        #1;
        checkOutput("release_ready", longint'(in_ready), 1);
        tick();
        checkOutput("drain_data2", longint'(out_data), 135);
        checkOutput("drain_valid2", longint'(out_valid), 1);
        tick();
        checkOutput("drain_empty", longint'(out_valid), 0);

        // Bubble: stage 2 stalled, stage 1 empty, a new beat is still accepted.
        applyStimulus(1'b1, 1, 1, 1, 1'b0);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        tick();
        checkOutput("bubble_valid", longint'(out_valid), 1);
        applyStimulus(1'b1, 3, 4, 5, 1'b0);
        #1;
        checkOutput("bubble_ready", longint'(in_ready), 1);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("bubble_full", longint'(in_ready), 0);
        checkOutput("bubble_data1", longint'(out_data), 2);
        out_ready = 1'b1;
        tick();
        checkOutput("bubble_data2", longint'(out_data), 35);
        tick();
        checkOutput("bubble_empty", longint'(out_valid), 0);

        // Randomized stream of 10000 beats with random backpressure.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
            tick();
            cyc++;
        end
        checkOutput("random_accepted", longint'(accepted), 10000);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            tick();
        end
        checkOutput("random_drained", longint'(exp_q.size()), 0);
`ifdef MAC_PIPE_STATS_EN
        checkOutput("random_beat_cnt", longint'(beat_cnt), 10000);
`endif

        // Reset with two beats in flight discards them.
        applyStimulus(1'b1, 50, 60, 70, 1'b0);
        tick();
        applyStimulus(1'b1, 11, 12, 13, 1'b0);
        tick();
        checkOutput("pre_reset_busy", longint'(busy), 1);
        rst = 1'b1;
        applyStimulus(1'b1, 99, 99, 99, 1'b1);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("mid_reset_valid", longint'(out_valid), 0);
        checkOutput("mid_reset_busy", longint'(busy), 0);
        checkOutput("mid_reset_data", longint'(out_data), 0);
`ifdef MAC_PIPE_STATS_EN
        checkOutput("mid_reset_beat_cnt", longint'(beat_cnt), 0);
        checkOutput("mid_reset_stall_cnt", longint'(stall_cnt), 0);
`endif
        applyStimulus(1'b1, 5, 6, 7, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("post_reset_n1", longint'(out_valid), 0);
        tick();
        checkOutput("post_reset_valid", longint'(out_valid), 1);
        checkOutput("post_reset_data", longint'(out_data), 77);
        tick();
        checkOutput("post_reset_empty", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
